// File: rtl/axi_types.sv
// Shared AXI encodings and read-id assignments used across the BIU.
// Every block that builds AR-channel payloads imports these rather than redefining them.
package axi_types;

  localparam logic [3:0] AXI_RID_IFU = 4'd1;
  localparam logic [3:0] AXI_RID_LSU = 4'd2;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0000;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

endpackage

// File: rtl/c7bbiu_rd_arb_pkg.sv
// Local types for the BIU read arbiter: FSM states and the requester payload bundle.
package c7bbiu_rd_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } rd_req_t;

  function automatic rd_req_t pack_req(input logic [31:0] addr,
                                       input logic [7:0]  len,
                                       input logic [2:0]  size);
    rd_req_t r;
    r.addr = addr;
    r.len  = len;
    r.size = size;
    return r;
  endfunction

endpackage

// File: rtl/c7bbiu_rd_arb_if.sv
// Bundle of requester, AR-issue and completion signals around the BIU read arbiter.
// The arbiter uses the master modport (it masters the AR channel); the environment uses slave.
interface c7bbiu_rd_arb_if;

  logic        ifu_rd_req;
  logic [31:0] ifu_rd_addr;
  logic [7:0]  ifu_rd_len;
  logic [2:0]  ifu_rd_size;
  logic        ifu_rd_ack;

  logic        lsu_rd_req;
  logic [31:0] lsu_rd_addr;
  logic [7:0]  lsu_rd_len;
  logic [2:0]  lsu_rd_size;
  logic        lsu_rd_ack;

  logic        arb_rd_val;
  logic [3:0]  arb_rd_id;
  logic [31:0] arb_rd_addr;
  logic [7:0]  arb_rd_len;
  logic [2:0]  arb_rd_size;
  logic [1:0]  arb_rd_burst;
  logic        arb_rd_lock;
  logic [3:0]  arb_rd_cache;
  logic [2:0]  arb_rd_prot;

  logic        axi_ar_ready;
  logic        axi_rdata_ifu_val;
  logic        axi_rdata_lsu_val;

  logic        ifu_rd_busy;
  logic        lsu_rd_busy;

  modport master (
    input  ifu_rd_req, ifu_rd_addr, ifu_rd_len, ifu_rd_size,
    input  lsu_rd_req, lsu_rd_addr, lsu_rd_len, lsu_rd_size,
    input  axi_ar_ready, axi_rdata_ifu_val, axi_rdata_lsu_val,
    output ifu_rd_ack, lsu_rd_ack,
    output arb_rd_val, arb_rd_id, arb_rd_addr, arb_rd_len, arb_rd_size,
    output arb_rd_burst, arb_rd_lock, arb_rd_cache, arb_rd_prot,
    output ifu_rd_busy, lsu_rd_busy
  );

  modport slave (
    output ifu_rd_req, ifu_rd_addr, ifu_rd_len, ifu_rd_size,
    output lsu_rd_req, lsu_rd_addr, lsu_rd_len, lsu_rd_size,
    output axi_ar_ready, axi_rdata_ifu_val, axi_rdata_lsu_val,
    input  ifu_rd_ack, lsu_rd_ack,
    input  arb_rd_val, arb_rd_id, arb_rd_addr, arb_rd_len, arb_rd_size,
    input  arb_rd_burst, arb_rd_lock, arb_rd_cache, arb_rd_prot,
    input  ifu_rd_busy, lsu_rd_busy
  );

endinterface

// File: rtl/c7bbiu_rr_pick2.sv
// Two-way IFU/LSU winner selection: fixed LSU priority or pointer-based round-robin.
module c7bbiu_rr_pick2 #(
  parameter int LSU_PRIO = 0
) (
  input  logic ifu_elig_i,
  input  logic lsu_elig_i,
  input  logic prefer_lsu_i,
  output logic grant_val_o,
  output logic grant_lsu_o
);

  // The pointer only breaks ties; a lone eligible requester always wins.
  always_comb begin
    grant_val_o = ifu_elig_i | lsu_elig_i;
    grant_lsu_o = 1'b0;
    if (LSU_PRIO != 0) begin
      grant_lsu_o = lsu_elig_i;
    end else if (ifu_elig_i && lsu_elig_i) begin
      grant_lsu_o = prefer_lsu_i;
    end else begin
      grant_lsu_o = lsu_elig_i;
    end
  end

endmodule

// File: rtl/c7bbiu_rd_arb.sv
// BIU read arbiter: picks IFU or LSU, holds the AR payload until the AXI side is ready,
// and tracks one outstanding read per requester.
module c7bbiu_rd_arb
  import axi_types::*;
  import c7bbiu_rd_arb_pkg::*;
#(
  parameter int LSU_PRIO    = 0,
  parameter int RR_INIT_LSU = 1
) (
  input  logic               clk,
  input  logic               reset,
  c7bbiu_rd_arb_if.master    bus
);

  arb_state_e  state_q, state_d;
  logic        ifu_out_q, ifu_out_d;
  logic        lsu_out_q, lsu_out_d;
  logic        rr_lsu_q, rr_lsu_d;
  logic        win_lsu_q, win_lsu_d;
  logic [3:0]  id_q, id_d;
  rd_req_t     req_q, req_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  cache_q, cache_d;
  logic [2:0]  prot_q, prot_d;

  logic        ifu_elig, lsu_elig;
  logic        pick_val, pick_lsu;
  logic        issue, ifu_set, lsu_set;
  rd_req_t     ifu_req, lsu_req;

  assign ifu_elig = bus.ifu_rd_req & ~ifu_out_q;
  assign lsu_elig = bus.lsu_rd_req & ~lsu_out_q;
  assign ifu_req  = pack_req(bus.ifu_rd_addr, bus.ifu_rd_len, bus.ifu_rd_size);
  assign lsu_req  = pack_req(bus.lsu_rd_addr, bus.lsu_rd_len, bus.lsu_rd_size);

  c7bbiu_rr_pick2 #(.LSU_PRIO(LSU_PRIO)) u_pick (
    .ifu_elig_i   (ifu_elig),
    .lsu_elig_i   (lsu_elig),
    .prefer_lsu_i (rr_lsu_q),
    .grant_val_o  (pick_val),
    .grant_lsu_o  (pick_lsu)
  );

  // Winner is frozen on entry to HOLD; issue is combinational on ready so no cycle is lost.
  always_comb begin
    state_d   = state_q;
    rr_lsu_d  = rr_lsu_q;
    win_lsu_d = win_lsu_q;
    id_d      = id_q;
    req_d     = req_q;
    burst_d   = burst_q;
    cache_d   = cache_q;
    prot_d    = prot_q;
    issue     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_val) begin
          state_d   = ARB_HOLD;
          win_lsu_d = pick_lsu;
          id_d      = pick_lsu ? AXI_RID_LSU : AXI_RID_IFU;
          req_d     = pick_lsu ? lsu_req : ifu_req;
          burst_d   = AXI_BURST_INCR;
          cache_d   = AXI_CACHE_DEFAULT;
          prot_d    = AXI_PROT_DEFAULT;
        end
      end
      ARB_HOLD: begin
        if (bus.axi_ar_ready) begin
          issue    = 1'b1;
          state_d  = ARB_IDLE;
          rr_lsu_d = ~win_lsu_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign ifu_set = issue & ~win_lsu_q;
  assign lsu_set = issue &  win_lsu_q;

  // A completion and a new issue for the same requester is illegal; if it happens the set wins.
  assign ifu_out_d = ifu_set | (ifu_out_q & ~bus.axi_rdata_ifu_val);
  assign lsu_out_d = lsu_set | (lsu_out_q & ~bus.axi_rdata_lsu_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      ifu_out_q <= 1'b0;
      lsu_out_q <= 1'b0;
      rr_lsu_q  <= (RR_INIT_LSU != 0);
      win_lsu_q <= 1'b0;
      id_q      <= '0;
      req_q     <= '0;
      burst_q   <= '0;
      cache_q   <= '0;
      prot_q    <= '0;
    end else begin
      state_q   <= state_d;
      ifu_out_q <= ifu_out_d;
      lsu_out_q <= lsu_out_d;
      rr_lsu_q  <= rr_lsu_d;
      win_lsu_q <= win_lsu_d;
      id_q      <= id_d;
      req_q     <= req_d;
      burst_q   <= burst_d;
      cache_q   <= cache_d;
      prot_q    <= prot_d;
    end
  end

  assign bus.arb_rd_val   = issue;
  assign bus.ifu_rd_ack   = ifu_set;
  assign bus.lsu_rd_ack   = lsu_set;
  assign bus.arb_rd_id    = id_q;
  assign bus.arb_rd_addr  = req_q.addr;
  assign bus.arb_rd_len   = req_q.len;
  assign bus.arb_rd_size  = req_q.size;
  assign bus.arb_rd_burst = burst_q;
  assign bus.arb_rd_lock  = 1'b0;
  assign bus.arb_rd_cache = cache_q;
  assign bus.arb_rd_prot  = prot_q;
  assign bus.ifu_rd_busy  = ifu_out_q;
  assign bus.lsu_rd_busy  = lsu_out_q;

  ifuSetClearCollide: assert property (@(posedge clk) disable iff (reset)
    !(ifu_set && bus.axi_rdata_ifu_val));
  lsuSetClearCollide: assert property (@(posedge clk) disable iff (reset)
    !(lsu_set && bus.axi_rdata_lsu_val));

endmodule

// File: tb/tb_c7bbiu_rd_arb.sv
// Self-checking bench for c7bbiu_rd_arb: vector table, directed corner sequences,
// and randomized stress against a transaction-level reference model.
module tb_c7bbiu_rd_arb;
  import axi_types::*;

  localparam logic [31:0] IFU_ADDR = 32'h1C00_0000;
  localparam logic [7:0]  IFU_LEN  = 8'd3;
  localparam logic [2:0]  IFU_SIZE = 3'd2;
  localparam logic [31:0] LSU_ADDR = 32'h0000_1000;
  localparam logic [7:0]  LSU_LEN  = 8'd7;
  localparam logic [2:0]  LSU_SIZE = 3'd3;

  typedef struct {
    logic       ifuReq, lsuReq, ready, ifuDone, lsuDone;
    logic       expVal, expIfuAck, expLsuAck;
    logic [3:0] expId;
    logic       expIfuBusy, expLsuBusy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  c7bbiu_rd_arb_if bus();
  c7bbiu_rd_arb_if busP();

  c7bbiu_rd_arb #(.LSU_PRIO(0), .RR_INIT_LSU(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  c7bbiu_rd_arb #(.LSU_PRIO(1), .RR_INIT_LSU(1)) dutPrio (
    .clk(clk), .reset(reset), .bus(busP)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic iR, lR, rdy, iD, lD,
                                 input logic eV, eIA, eLA, input logic [3:0] eId,
                                 input logic eIB, eLB);
    vec_t v;
    v.ifuReq = iR; v.lsuReq = lR; v.ready = rdy; v.ifuDone = iD; v.lsuDone = lD;
    v.expVal = eV; v.expIfuAck = eIA; v.expLsuAck = eLA; v.expId = eId;
    v.expIfuBusy = eIB; v.expLsuBusy = eLB;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge on the chosen instance, then lets logic settle.
  task automatic applyStimulus(input bit usePrio, input logic iR, lR, rdy, iD, lD);
    @(negedge clk);
    if (usePrio) begin
      busP.ifu_rd_req = iR; busP.lsu_rd_req = lR; busP.axi_ar_ready = rdy;
      busP.axi_rdata_ifu_val = iD; busP.axi_rdata_lsu_val = lD;
    end else begin
      bus.ifu_rd_req = iR; bus.lsu_rd_req = lR; bus.axi_ar_ready = rdy;
      bus.axi_rdata_ifu_val = iD; bus.axi_rdata_lsu_val = lD;
    end
    #2;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, " val"},    32'(bus.arb_rd_val), 32'd0);
    checkOutput({tag, " ifuAck"}, 32'(bus.ifu_rd_ack), 32'd0);
    checkOutput({tag, " lsuAck"}, 32'(bus.lsu_rd_ack), 32'd0);
    checkOutput({tag, " id"},     32'(bus.arb_rd_id), 32'd0);
    checkOutput({tag, " addr"},   bus.arb_rd_addr, 32'd0);
    checkOutput({tag, " len"},    32'(bus.arb_rd_len), 32'd0);
    checkOutput({tag, " size"},   32'(bus.arb_rd_size), 32'd0);
    checkOutput({tag, " burst"},  32'(bus.arb_rd_burst), 32'd0);
    checkOutput({tag, " lock"},   32'(bus.arb_rd_lock), 32'd0);
    checkOutput({tag, " cache"},  32'(bus.arb_rd_cache), 32'd0);
    checkOutput({tag, " prot"},   32'(bus.arb_rd_prot), 32'd0);
    checkOutput({tag, " ifuBusy"}, 32'(bus.ifu_rd_busy), 32'd0);
    checkOutput({tag, " lsuBusy"}, 32'(bus.lsu_rd_busy), 32'd0);
    checkOutput({tag, " P val"},  32'(busP.arb_rd_val), 32'd0);
    checkOutput({tag, " P id"},   32'(busP.arb_rd_id), 32'd0);
  endtask

  task automatic clearInputs();
    bus.ifu_rd_req = 1'b0; bus.lsu_rd_req = 1'b0; bus.axi_ar_ready = 1'b0;
    bus.axi_rdata_ifu_val = 1'b0; bus.axi_rdata_lsu_val = 1'b0;
    busP.ifu_rd_req = 1'b0; busP.lsu_rd_req = 1'b0; busP.axi_ar_ready = 1'b0;
    busP.axi_rdata_ifu_val = 1'b0; busP.axi_rdata_lsu_val = 1'b0;
  endtask

  task automatic setFixedPayload();
    bus.ifu_rd_addr = IFU_ADDR; bus.ifu_rd_len = IFU_LEN; bus.ifu_rd_size = IFU_SIZE;
    bus.lsu_rd_addr = LSU_ADDR; bus.lsu_rd_len = LSU_LEN; bus.lsu_rd_size = LSU_SIZE;
    busP.ifu_rd_addr = IFU_ADDR; busP.ifu_rd_len = IFU_LEN; busP.ifu_rd_size = IFU_SIZE;
    busP.lsu_rd_addr = LSU_ADDR; busP.lsu_rd_len = LSU_LEN; busP.lsu_rd_size = LSU_SIZE;
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    clearInputs();
    #2;
    checkZero({tag, " in"});
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkZero({tag, " out"});
  endtask

  task automatic checkIssue(input string tag, input logic expIfu);
    checkOutput({tag, " val"},    32'(bus.arb_rd_val), 32'd1);
    checkOutput({tag, " ifuAck"}, 32'(bus.ifu_rd_ack), 32'(expIfu));
    checkOutput({tag, " lsuAck"}, 32'(bus.lsu_rd_ack), 32'(!expIfu));
    checkOutput({tag, " id"},     32'(bus.arb_rd_id), 32'(expIfu ? AXI_RID_IFU : AXI_RID_LSU));
    checkOutput({tag, " addr"},   bus.arb_rd_addr, expIfu ? IFU_ADDR : LSU_ADDR);
  endtask

  // Stress model state: requests as transactions, one pending grant, one outstanding flag each.
  int          pend;
  bit          outst[2];
  bit          ptrLsu;
  bit          reqOn[2];
  bit          doneNow[2];
  logic [31:0] rAddr[2];
  logic [7:0]  rLen[2];
  logic [2:0]  rSize[2];
  logic [31:0] pAddr;
  logic [7:0]  pLen;
  logic [2:0]  pSize;

  task automatic newPayload(input int i);
    rAddr[i] = $urandom;
    rLen[i]  = 8'($urandom_range(0, 255));
    rSize[i] = 3'($urandom_range(0, 7));
  endtask

  task automatic runStress(input int cycles);
    bit expVal, rdy, eI, eL;
    int win;
    pend = -1; outst[0] = 0; outst[1] = 0; ptrLsu = 1'b1;
    reqOn[0] = 0; reqOn[1] = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!reqOn[i] && $urandom_range(0, 2) == 0) begin
          reqOn[i] = 1'b1;
          newPayload(i);
        end
        doneNow[i] = outst[i] && ($urandom_range(0, 3) == 0);
      end
      bus.axi_ar_ready = rdy;
      bus.ifu_rd_req = reqOn[0]; bus.ifu_rd_addr = rAddr[0];
      bus.ifu_rd_len = rLen[0];  bus.ifu_rd_size = rSize[0];
      bus.lsu_rd_req = reqOn[1]; bus.lsu_rd_addr = rAddr[1];
      bus.lsu_rd_len = rLen[1];  bus.lsu_rd_size = rSize[1];
      bus.axi_rdata_ifu_val = doneNow[0];
      bus.axi_rdata_lsu_val = doneNow[1];
      #2;
      expVal = (pend >= 0) && rdy;
      checkOutput("st val", 32'(bus.arb_rd_val), 32'(expVal));
      checkOutput("st ifuAck", 32'(bus.ifu_rd_ack), 32'(expVal && pend == 0));
      checkOutput("st lsuAck", 32'(bus.lsu_rd_ack), 32'(expVal && pend == 1));
      checkOutput("st ifuBusy", 32'(bus.ifu_rd_busy), 32'(outst[0]));
      checkOutput("st lsuBusy", 32'(bus.lsu_rd_busy), 32'(outst[1]));
      checkOutput("st valNoReady", 32'(bus.arb_rd_val & ~bus.axi_ar_ready), 32'd0);
      checkOutput("st ifuDouble", 32'(bus.ifu_rd_ack & bus.ifu_rd_busy), 32'd0);
      checkOutput("st lsuDouble", 32'(bus.lsu_rd_ack & bus.lsu_rd_busy), 32'd0);
      if (pend >= 0) begin
        checkOutput("st id", 32'(bus.arb_rd_id), 32'(pend == 1 ? AXI_RID_LSU : AXI_RID_IFU));
        checkOutput("st addr", bus.arb_rd_addr, pAddr);
        checkOutput("st len", 32'(bus.arb_rd_len), 32'(pLen));
        checkOutput("st size", 32'(bus.arb_rd_size), 32'(pSize));
        checkOutput("st burst", 32'(bus.arb_rd_burst), 32'(AXI_BURST_INCR));
      end
      if (expVal) begin
        outst[pend] = 1'b1;
        ptrLsu = (pend == 0);
        if ($urandom_range(0, 1) == 0) reqOn[pend] = 1'b0;
        else newPayload(pend);
        pend = -1;
      end else if (pend < 0) begin
        eI = reqOn[0] && !outst[0];
        eL = reqOn[1] && !outst[1];
        win = -1;
        if (eI && eL) win = ptrLsu ? 1 : 0;
        else if (eI)  win = 0;
        else if (eL)  win = 1;
        if (win >= 0) begin
          pend = win; pAddr = rAddr[win]; pLen = rLen[win]; pSize = rSize[win];
        end
      end
      for (int i = 0; i < 2; i++) if (doneNow[i]) outst[i] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    setFixedPayload();

    // Both requesting after reset (LSU first), then a lone IFU held across its own busy window.
    vecs.push_back(mkVec(1,1,1,0,0, 0,0,0, 4'd0,        0,0));
    vecs.push_back(mkVec(1,1,1,0,0, 1,0,1, AXI_RID_LSU, 0,0));
    vecs.push_back(mkVec(1,1,1,0,0, 0,0,0, 4'd0,        0,1));
    vecs.push_back(mkVec(1,1,1,0,0, 1,1,0, AXI_RID_IFU, 0,1));
    vecs.push_back(mkVec(0,0,1,0,0, 0,0,0, 4'd0,        1,1));
    vecs.push_back(mkVec(0,0,1,0,1, 0,0,0, 4'd0,        1,1));
    vecs.push_back(mkVec(0,0,1,1,0, 0,0,0, 4'd0,        1,0));
    vecs.push_back(mkVec(0,0,1,0,0, 0,0,0, 4'd0,        0,0));
    vecs.push_back(mkVec(1,0,1,0,0, 0,0,0, 4'd0,        0,0));
    vecs.push_back(mkVec(1,0,1,0,0, 1,1,0, AXI_RID_IFU, 0,0));
    vecs.push_back(mkVec(1,0,1,0,0, 0,0,0, 4'd0,        1,0));
    vecs.push_back(mkVec(1,0,1,0,0, 0,0,0, 4'd0,        1,0));
    vecs.push_back(mkVec(1,0,1,1,0, 0,0,0, 4'd0,        1,0));
    vecs.push_back(mkVec(1,0,1,0,0, 0,0,0, 4'd0,        0,0));
    vecs.push_back(mkVec(1,0,1,0,0, 1,1,0, AXI_RID_IFU, 0,0));
    vecs.push_back(mkVec(0,0,1,0,0, 0,0,0, 4'd0,        1,0));
    vecs.push_back(mkVec(0,0,1,1,0, 0,0,0, 4'd0,        1,0));
    vecs.push_back(mkVec(0,0,1,0,0, 0,0,0, 4'd0,        0,0));

    doReset("rst0");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].ifuReq, vecs[i].lsuReq, vecs[i].ready,
                    vecs[i].ifuDone, vecs[i].lsuDone);
      checkOutput($sformatf("row%0d val", i), 32'(bus.arb_rd_val), 32'(vecs[i].expVal));
      checkOutput($sformatf("row%0d ifuAck", i), 32'(bus.ifu_rd_ack), 32'(vecs[i].expIfuAck));
      checkOutput($sformatf("row%0d lsuAck", i), 32'(bus.lsu_rd_ack), 32'(vecs[i].expLsuAck));
      checkOutput($sformatf("row%0d ifuBusy", i), 32'(bus.ifu_rd_busy), 32'(vecs[i].expIfuBusy));
      checkOutput($sformatf("row%0d lsuBusy", i), 32'(bus.lsu_rd_busy), 32'(vecs[i].expLsuBusy));
      if (vecs[i].expVal) begin
        checkOutput($sformatf("row%0d id", i), 32'(bus.arb_rd_id), 32'(vecs[i].expId));
        checkOutput($sformatf("row%0d addr", i), bus.arb_rd_addr,
                    (vecs[i].expId == AXI_RID_IFU) ? IFU_ADDR : LSU_ADDR);
        checkOutput($sformatf("row%0d len", i), 32'(bus.arb_rd_len),
                    32'((vecs[i].expId == AXI_RID_IFU) ? IFU_LEN : LSU_LEN));
        checkOutput($sformatf("row%0d size", i), 32'(bus.arb_rd_size),
                    32'((vecs[i].expId == AXI_RID_IFU) ? IFU_SIZE : LSU_SIZE));
        checkOutput($sformatf("row%0d burst", i), 32'(bus.arb_rd_burst), 32'(AXI_BURST_INCR));
      end
    end

    // LSU held in HOLD by a stalled AR channel; IFU arriving meanwhile must not steal the grant.
    doReset("rst1");
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("stall select val", 32'(bus.arb_rd_val), 32'd0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, (k >= 2), 1, 0, 0, 0);
      checkOutput($sformatf("stall%0d val", k), 32'(bus.arb_rd_val), 32'd0);
      checkOutput($sformatf("stall%0d lsuAck", k), 32'(bus.lsu_rd_ack), 32'd0);
      checkOutput($sformatf("stall%0d ifuAck", k), 32'(bus.ifu_rd_ack), 32'd0);
      checkOutput($sformatf("stall%0d id", k), 32'(bus.arb_rd_id), 32'(AXI_RID_LSU));
      checkOutput($sformatf("stall%0d addr", k), bus.arb_rd_addr, LSU_ADDR);
    end
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkIssue("stall release", 1'b0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkOutput("stall gap val", 32'(bus.arb_rd_val), 32'd0);
    checkOutput("stall gap lsuBusy", 32'(bus.lsu_rd_busy), 32'd1);
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkIssue("stall ifu after", 1'b1);
    applyStimulus(0, 0, 0, 1, 1, 1);

    // Reset landing in HOLD drops the grant; the still-held request is reissued afterwards.
    doReset("rst2");
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("hold id", 32'(bus.arb_rd_id), 32'(AXI_RID_IFU));
    checkOutput("hold val", 32'(bus.arb_rd_val), 32'd0);
    reset = 1'b1;
    bus.axi_ar_ready = 1'b1;
    #1;
    checkZero("midhold rst");
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkZero("midhold rel");
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkIssue("midhold regrant", 1'b1);

    // Fixed LSU priority: LSU wins every simultaneous request, even right after its own issue.
    doReset("rst3");
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1, 1, 1, 1, 0, 0);
      checkOutput($sformatf("prio%0d sel val", r), 32'(busP.arb_rd_val), 32'd0);
      applyStimulus(1, 1, 1, 1, 0, 0);
      checkOutput($sformatf("prio%0d val", r), 32'(busP.arb_rd_val), 32'd1);
      checkOutput($sformatf("prio%0d lsuAck", r), 32'(busP.lsu_rd_ack), 32'd1);
      checkOutput($sformatf("prio%0d ifuAck", r), 32'(busP.ifu_rd_ack), 32'd0);
      checkOutput($sformatf("prio%0d id", r), 32'(busP.arb_rd_id), 32'(AXI_RID_LSU));
      applyStimulus(1, 0, 0, 1, 0, 1);
      checkOutput($sformatf("prio%0d busy", r), 32'(busP.lsu_rd_busy), 32'd1);
      applyStimulus(1, 0, 0, 1, 0, 0);
      checkOutput($sformatf("prio%0d idle", r), 32'(busP.lsu_rd_busy), 32'd0);
    end

    doReset("rst4");
    runStress(10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
